// File: rtl/ysyx_25040111_icache_refill.sv
// Refill bridge between the instruction cache and an AXI4 read port.
// Turns a one-cycle miss pulse into one AR/R burst and returns the block with a one-cycle rok pulse.
module ysyx_25040111_icache_refill #(
    parameter int         BEATS  = 1,
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           req_addr,
    input  logic                  rstart,
    output logic                  rok,
    output logic [32*BEATS-1:0]   rdata,
    output logic                  rerr,
    output logic                  busy,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [31:0]           araddr,
    output logic [3:0]            arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic [3:0]            rid
);

    localparam int              OFF       = $clog2(BEATS * 4);
    localparam int              CW        = $clog2(BEATS) + 1;
    localparam logic [31:0]     ADDR_MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(BEATS);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   err_reg, err_next;
    logic                   beat_fire;
    logic [32*BEATS-1:0]    blk_reg, blk_next;
    logic [32*BEATS-1:0]    rdata_reg;
    logic                   rok_reg, rerr_reg, busy_reg, arvalid_reg, rready_reg;
    logic [31:0]            araddr_reg;
    logic [3:0]             arid_reg;
    logic [7:0]             arlen_reg;
    logic [2:0]             arsize_reg;
    logic [1:0]             arburst_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        beat_fire  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (rstart) begin
                    state_next = S_AR;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end
            end
            S_AR: begin
                if (arvalid_reg && arready) state_next = S_R;
            end
            S_R: begin
                if (rvalid && rready_reg) begin
                    beat_fire = 1'b1;
                    // Counter saturates at BEATS; surplus beats only flag an error.
                    if (cnt_reg < CNT_FULL) cnt_next = cnt_reg + CW'(1);
                    else                    err_next = 1'b1;
                    if (rresp != 2'b00 || rid != AXI_ID) err_next = 1'b1;
                    if (rlast) begin
                        if (cnt_reg != CNT_LAST) err_next = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Slot write-through, so the final beat is visible in the same edge that enters DONE.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            assign blk_next[32*gi +: 32] = (beat_fire && cnt_reg == CW'(gi)) ? axi_rdata
                                                                              : blk_reg[32*gi +: 32];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            blk_reg     <= '0;
            rdata_reg   <= '0;
            rok_reg     <= 1'b0;
            rerr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            araddr_reg  <= '0;
            arid_reg    <= '0;
            arlen_reg   <= '0;
            arsize_reg  <= '0;
            arburst_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            blk_reg     <= blk_next;
            busy_reg    <= (state_next != S_IDLE);
            arvalid_reg <= (state_next == S_AR);
            rready_reg  <= (state_next == S_R);
            rok_reg     <= (state_next == S_DONE);
            rerr_reg    <= (state_next == S_DONE) && err_next;
            if (state_next == S_DONE) rdata_reg <= blk_next;
            if (state_reg == S_IDLE && rstart) begin
                araddr_reg  <= req_addr & ADDR_MASK;
                arid_reg    <= AXI_ID;
                arlen_reg   <= 8'(BEATS - 1);
                arsize_reg  <= 3'b010;
                arburst_reg <= 2'b01;
            end
        end
    end

    assign rok     = rok_reg;
    assign rdata   = rdata_reg;
    assign rerr    = rerr_reg;
    assign busy    = busy_reg;
    assign arvalid = arvalid_reg;
    assign rready  = rready_reg;
    assign araddr  = araddr_reg;
    assign arid    = arid_reg;
    assign arlen   = arlen_reg;
    assign arsize  = arsize_reg;
    assign arburst = arburst_reg;

endmodule

// File: tb/tb_ysyx_25040111_icache_refill.sv
// Bench for the icache refill bridge: three instances (BEATS = 1, 2, 4) driven by a scripted
// AXI slave, with expected blocks and error flags taken from a per-instance slot model.
module tb_ysyx_25040111_icache_refill;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [2:0]  rstart_v, arready_v, rvalid_v, rlast_v;
    logic [31:0] req_addr_v  [3];
    logic [31:0] axi_rdata_v [3];
    logic [1:0]  rresp_v     [3];
    logic [3:0]  rid_v       [3];
    wire  [2:0]  rok_v, rerr_v, busy_v, arvalid_v, rready_v;
    wire  [31:0] araddr_v    [3];
    wire  [3:0]  arid_v      [3];
    wire  [7:0]  arlen_v     [3];
    wire  [2:0]  arsize_v    [3];
    wire  [1:0]  arburst_v   [3];
    wire  [127:0] rdata_v    [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int B = 1 << gi;
            wire [32*B-1:0] rd;
            ysyx_25040111_icache_refill #(.BEATS(B), .AXI_ID(4'h0)) dut (
                .clock(clock), .reset(reset),
                .req_addr(req_addr_v[gi]), .rstart(rstart_v[gi]),
                .rok(rok_v[gi]), .rdata(rd), .rerr(rerr_v[gi]), .busy(busy_v[gi]),
                .arvalid(arvalid_v[gi]), .arready(arready_v[gi]), .araddr(araddr_v[gi]),
                .arid(arid_v[gi]), .arlen(arlen_v[gi]), .arsize(arsize_v[gi]),
                .arburst(arburst_v[gi]),
                .rvalid(rvalid_v[gi]), .rready(rready_v[gi]), .axi_rdata(axi_rdata_v[gi]),
                .rresp(rresp_v[gi]), .rlast(rlast_v[gi]), .rid(rid_v[gi])
            );
            assign rdata_v[gi] = 128'(rd);
        end
    endgenerate

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] beat_data [16];
    logic [31:0] exp_blk   [3][8];

    // One full refill on instance k; bad_resp/bad_id give the beat index to corrupt (-1 = none).
    task automatic refill(input int k, input logic [31:0] addr, input int nb, input int gap,
                          input int ar_wait, input int bad_resp, input int bad_id,
                          input bit poke_rstart);
        int          b;
        int          g;
        int          cyc;
        logic [31:0] exp_addr;
        logic [127:0] exp_rdata;
        logic        exp_err;
        b         = 1 << k;
        exp_addr  = addr & ~(32'(b * 4) - 32'd1);
        exp_err   = (nb != b) || (bad_resp >= 0 && bad_resp < nb) || (bad_id >= 0 && bad_id < nb);
        for (int i = 0; i < nb && i < b; i++) exp_blk[k][i] = beat_data[i];
        exp_rdata = '0;
        for (int i = 0; i < b; i++) exp_rdata[32*i +: 32] = exp_blk[k][i];

        req_addr_v[k] = addr;
        rstart_v[k]   = 1'b1;
        @(posedge clock); #1;
        rstart_v[k]   = 1'b0;
        req_addr_v[k] = $urandom;
        cyc = 1;
        n_checks++;
        if ({arvalid_v[k], busy_v[k], rready_v[k], rok_v[k]} !== 4'b1100)
            $display("FAIL ar_start inst=%0d got arvalid,busy,rready,rok=%b want 1100", k,
                     {arvalid_v[k], busy_v[k], rready_v[k], rok_v[k]});
        else n_pass++;
        n_checks++;
        if ({araddr_v[k], arid_v[k], arlen_v[k], arsize_v[k], arburst_v[k]} !==
            {exp_addr, 4'h0, 8'(b - 1), 3'b010, 2'b01})
            $display("FAIL ar_fields inst=%0d got addr=%h id=%h len=%0d size=%b burst=%b want addr=%h len=%0d",
                     k, araddr_v[k], arid_v[k], arlen_v[k], arsize_v[k], arburst_v[k], exp_addr, b - 1);
        else n_pass++;

        for (int w = 0; w < ar_wait; w++) begin
            if (poke_rstart) begin
                rstart_v[k]   = 1'b1;
                req_addr_v[k] = $urandom;
            end
            @(posedge clock); #1;
            rstart_v[k] = 1'b0;
            cyc++;
            n_checks++;
            if ({arvalid_v[k], rready_v[k], araddr_v[k]} !== {2'b10, exp_addr})
                $display("FAIL ar_stall inst=%0d wait=%0d got arvalid=%b rready=%b addr=%h want 1 0 %h",
                         k, w, arvalid_v[k], rready_v[k], araddr_v[k], exp_addr);
            else n_pass++;
        end

        arready_v[k] = 1'b1;
        @(posedge clock); #1;
        arready_v[k] = 1'b0;
        cyc++;
        n_checks++;
        if ({arvalid_v[k], rready_v[k]} !== 2'b01)
            $display("FAIL r_enter inst=%0d got arvalid,rready=%b want 01", k, {arvalid_v[k], rready_v[k]});
        else n_pass++;

        for (int j = 0; j < nb; j++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(posedge clock); #1;
                cyc++;
            end
            rvalid_v[k]    = 1'b1;
            axi_rdata_v[k] = beat_data[j];
            rresp_v[k]     = (j == bad_resp) ? 2'b10 : 2'b00;
            rid_v[k]       = (j == bad_id) ? 4'h3 : 4'h0;
            rlast_v[k]     = (j == nb - 1);
            @(posedge clock); #1;
            cyc++;
            rvalid_v[k] = 1'b0;
            rlast_v[k]  = 1'b0;
            rresp_v[k]  = 2'b00;
            rid_v[k]    = 4'h0;
            if (j < nb - 1) begin
                n_checks++;
                if ({rok_v[k], rready_v[k]} !== 2'b01)
                    $display("FAIL mid_burst inst=%0d beat=%0d got rok,rready=%b want 01", k, j,
                             {rok_v[k], rready_v[k]});
                else n_pass++;
            end
        end

        n_checks++;
        if ({rok_v[k], rerr_v[k]} !== {1'b1, exp_err})
            $display("FAIL done inst=%0d beats=%0d got rok=%b rerr=%b want 1 %b", k, nb,
                     rok_v[k], rerr_v[k], exp_err);
        else n_pass++;
        n_checks++;
        if (rdata_v[k] !== exp_rdata)
            $display("FAIL rdata inst=%0d got %h want %h", k, rdata_v[k], exp_rdata);
        else n_pass++;
        n_checks++;
        if ({busy_v[k], rready_v[k], arvalid_v[k]} !== 3'b100)
            $display("FAIL done_flags inst=%0d got busy,rready,arvalid=%b want 100", k,
                     {busy_v[k], rready_v[k], arvalid_v[k]});
        else n_pass++;
        if (b == 1 && gap == 0 && ar_wait == 0) begin
            n_checks++;
            if (cyc !== 3) $display("FAIL latency inst=%0d got %0d cycles want 3", k, cyc);
            else n_pass++;
        end
        $display("refill inst=%0d addr=%h beats=%0d rerr=%b rdata=%h cycles=%0d", k, addr, nb,
                 rerr_v[k], rdata_v[k], cyc);

        if (poke_rstart) rstart_v[k] = 1'b1;
        @(posedge clock); #1;
        rstart_v[k] = 1'b0;
        n_checks++;
        if ({rok_v[k], busy_v[k], arvalid_v[k], rdata_v[k]} !== {3'b000, exp_rdata})
            $display("FAIL idle_after inst=%0d got rok,busy,arvalid=%b rdata=%h want 000 %h", k,
                     {rok_v[k], busy_v[k], arvalid_v[k]}, rdata_v[k], exp_rdata);
        else n_pass++;
    endtask

    task automatic check_zero(input int k, input string tag);
        n_checks++;
        if ({rok_v[k], rerr_v[k], busy_v[k], arvalid_v[k], rready_v[k], araddr_v[k], arid_v[k],
             arlen_v[k], arsize_v[k], arburst_v[k], rdata_v[k]} !== '0)
            $display("FAIL %s inst=%0d got flags=%b araddr=%h arlen=%0d rdata=%h want all zero", tag, k,
                     {rok_v[k], rerr_v[k], busy_v[k], arvalid_v[k], rready_v[k]}, araddr_v[k],
                     arlen_v[k], rdata_v[k]);
        else n_pass++;
        $display("%s inst=%0d checked", tag, k);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) check_zero(k, "reset");
        #2 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_beat;
        beat_data[0] = 32'hDEADBEEF;
        refill(0, 32'h8000_0104, 1, 0, 0, -1, -1, 1'b0);
    endtask

    task automatic test_burst4;
        beat_data[0] = 32'h11; beat_data[1] = 32'h22;
        beat_data[2] = 32'h33; beat_data[3] = 32'h44;
        refill(2, 32'h8000_001C, 4, 2, 0, -1, -1, 1'b0);
    endtask

    task automatic test_ar_stall;
        beat_data[0] = $urandom; beat_data[1] = $urandom;
        refill(1, $urandom, 2, -1, 5, -1, -1, 1'b1);
    endtask

    task automatic test_errors;
        beat_data[0] = $urandom;
        refill(0, $urandom, 1, 0, 0, 0, -1, 1'b0);
        beat_data[0] = $urandom;
        refill(0, $urandom, 1, 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_early_last;
        beat_data[0] = $urandom; beat_data[1] = $urandom;
        refill(2, $urandom, 2, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 3; i++) beat_data[i] = $urandom;
        refill(1, $urandom, 3, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        int k;
        int b;
        int nb;
        for (int t = 0; t < 12; t++) begin
            k  = int'($urandom_range(0, 2));
            b  = 1 << k;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, b + 2)) : b;
            for (int i = 0; i < nb; i++) beat_data[i] = $urandom;
            refill(k, $urandom, nb, -1, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nb - 1)) : -1,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nb - 1)) : -1,
                   1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_midflight;
        req_addr_v[2] = $urandom;
        rstart_v[2]   = 1'b1;
        @(posedge clock); #1;
        rstart_v[2]   = 1'b0;
        arready_v[2]  = 1'b1;
        @(posedge clock); #1;
        arready_v[2]   = 1'b0;
        rvalid_v[2]    = 1'b1;
        axi_rdata_v[2] = $urandom;
        @(posedge clock); #1;
        rvalid_v[2] = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_zero(2, "reset_midflight");
        check_zero(0, "reset_midflight");
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) exp_blk[k][i] = '0;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) beat_data[i] = $urandom;
        refill(2, $urandom, 4, -1, 0, -1, -1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        rstart_v  = '0;
        arready_v = '0;
        rvalid_v  = '0;
        rlast_v   = '0;
        for (int k = 0; k < 3; k++) begin
            req_addr_v[k]  = '0;
            axi_rdata_v[k] = '0;
            rresp_v[k]     = '0;
            rid_v[k]       = '0;
            for (int i = 0; i < 8; i++) exp_blk[k][i] = '0;
        end
        test_reset;
        test_single_beat;
        test_burst4;
        test_ar_stall;
        test_errors;
        test_early_last;
        test_overflow;
        test_back_to_back;
        test_reset_midflight;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_icache_refill.md
# ysyx_25040111_icache_refill

Refill bridge directly downstream of the instruction cache: on a one-cycle miss request it fetches the missing block over an AXI4 read channel and returns it with a one-cycle completion pulse. It converts the cache's pulse-style `rstart`/`rok` refill handshake into a full AXI4 AR/R transaction, with optional multi-beat INCR bursts for wider cache blocks. Exactly one refill is outstanding at a time.

## Interface
- `BEATS`, 1: beats per refill (1, 2, 4 or 8); block width = 32*BEATS.
- `AXI_ID`, 4'h0: constant ARID; also the only accepted RID.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_addr` in 32: miss address; sampled only in the cycle `rstart`=1.
- `rstart` in 1: one-cycle refill request pulse from cache.
- `rok` out 1: one-cycle completion pulse to cache.
- `rdata` out 32*BEATS: refilled block, beat i in bits [32i+31:32i]; valid while `rok`=1, held until next completion.
- `rerr` out 1: valid with `rok`; 1 = refill faulted.
- `busy` out 1: 1 whenever state != IDLE.
- `arvalid` out 1, `arready` in 1, `araddr` out 32, `arid` out 4, `arlen` out 8, `arsize` out 3, `arburst` out 2: AXI4 read-address channel.
- `rvalid` in 1, `rready` out 1, `axi_rdata` in 32, `rresp` in 2, `rlast` in 1, `rid` in 4: AXI4 read-data channel.

## Operation
- FSM states: IDLE, AR, R, DONE. All outputs registered.
- IDLE: `rstart`=1 -> latch `req_addr` with low log2(BEATS*4) bits cleared, clear beat counter and error flag, -> AR.
- AR: `arvalid`=1, `araddr`=latched address, `arid`=AXI_ID, `arlen`=BEATS-1, `arsize`=3'b010, `arburst`=2'b01 (INCR). `araddr` and attributes stable while `arvalid`=1. On `arvalid`&`arready` -> R.
- R: `rready`=1. Each `rvalid`&`rready` beat:
  - beat counter < BEATS: store `axi_rdata` into slot[counter], counter+1.
  - counter already = BEATS: discard data, set error.
  - `rresp` != 2'b00 or `rid` != AXI_ID: set error; data still stored.
  - `rlast`=1: if counter before this beat != BEATS-1, set error; -> DONE.
- Early `rlast`: unfilled slots keep previous contents.
- Missing `rlast`: keep draining beats until `rlast` arrives.
- DONE: `rok`=1 and `rerr`=error flag for exactly one cycle; -> IDLE.
- `rstart` outside IDLE, including in DONE, is ignored; no queueing.
- Counter width: clog2(BEATS)+1 bits, saturates at BEATS; never wraps.

## Timing
- Reset, asynchronous: state IDLE; `rok`, `rerr`, `busy`, `arvalid`, `rready` = 0; `araddr`, `arid`, `arlen`, `arsize`, `arburst` = 0; `rdata` = 0. An in-flight transaction is abandoned, with no drain. The AXI slave shares the reset.
- `rstart` at cycle 0 -> `arvalid`=1 and `busy`=1 at cycle 1.
- AR handshake at cycle n -> `rready`=1 from cycle n+1.
- Final beat at cycle m -> `rok`=1 at cycle m+1 -> `busy`=0 at cycle m+2.
- Minimum `rstart`->`rok` latency, BEATS=1, zero-wait slave: 3 cycles. Each extra beat adds >=1 cycle.
- `arvalid` deasserts in the cycle after the handshake. `rready`=0 outside R.
- Back-to-back: the cache may issue the next `rstart` in the cycle after `rok`, which is in IDLE; it is accepted.

## Test plan
- BEATS=1, `req_addr`=0x8000_0104, `rstart` pulse, `arready`=1 at once, R beat 0xDEADBEEF with OKAY and `rlast` next cycle -> `araddr`=0x8000_0104, `arlen`=0, `rok` 3 cycles after `rstart`, `rdata`=0xDEADBEEF, `rerr`=0.
- BEATS=4, `req_addr`=0x8000_001C, beats 0x11,0x22,0x33,0x44 with 2-cycle `rvalid` gaps -> `araddr`=0x8000_0010, `arlen`=3, `arburst`=01, `rdata`=0x00000044_00000033_00000022_00000011, `rerr`=0.
- `arready` held low 5 cycles -> `arvalid`=1 and `araddr` stable all 5 cycles; no `rready` before the handshake; second `rstart` during the wait is ignored, so exactly one AR issues.
- BEATS=1, `rresp`=2'b10 (SLVERR) -> `rok`=1 with `rerr`=1, `rdata`=beat data. Separately, `rid`=4'h3 -> `rerr`=1.
- BEATS=4, `rlast` on beat 2 -> `rok`, `rerr`=1. BEATS=2 with 3 beats, `rlast` on beat 3 -> beat 3 discarded, `rerr`=1, `rok` after beat 3.
- Assert `reset` mid-R after 1 of 4 beats -> all outputs 0 immediately, with no clock edge needed. After release a new `rstart` completes normally with `rerr`=0.
